// File: rtl/zoom_pkg.sv
// zoom_pkg: shared types, copy-index constants and geometry helpers for the 2x zoom path
package zoom_pkg;
    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
    localparam logic [1:0] TL = 2'd0;
    localparam logic [1:0] TR = 2'd1;
    localparam logic [1:0] BL = 2'd2;
    localparam logic [1:0] BR = 2'd3;
    function automatic int dst_width(input int src_w);
        return 2 * src_w;
    endfunction
    function automatic bit addr_w_ok(input int addr_w, input int src_w, input int src_h);
        return (longint'(1) << addr_w) >= longint'(4) * longint'(src_w) * longint'(src_h);
    endfunction
endpackage

// File: rtl/zoom2x_addr_gen.sv
// zoom2x_addr_gen: source x/y tracking and multiplier-free destination address composition
module zoom2x_addr_gen
    import zoom_pkg::*;
#(
    parameter int SRC_W  = 160,
    parameter int SRC_H  = 120,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              advance,
    input  logic [1:0]        idx,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    localparam int DST_W = dst_width(SRC_W);
    localparam int SXW = SRC_W > 1 ? $clog2(SRC_W) : 1;
    localparam int SYW = SRC_H > 1 ? $clog2(SRC_H) : 1;
    logic [SXW-1:0]    sx;
    logic [SYW-1:0]    sy;
    logic [ADDR_W-1:0] row_base;
    logic              sx_wrap;
    assign sx_wrap = sx == SXW'(SRC_W - 1);
    assign last = sx_wrap && sy == SYW'(SRC_H - 1);
    // {sx, dx} is 2*sx + dx; the dy row is one destination row below row_base
    assign addr = row_base + (idx[1] ? ADDR_W'(DST_W) : '0) + ADDR_W'({sx, idx[0]});
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            sx       <= '0;
            sy       <= '0;
            row_base <= '0;
        end else if (advance) begin
            sx       <= sx_wrap ? '0 : sx + 1'b1;
            sy       <= sx_wrap ? sy + 1'b1 : sy;
            row_base <= sx_wrap ? row_base + ADDR_W'(2 * DST_W) : row_base;
        end
    end
endmodule

// File: rtl/zoom2x_frame_writer.sv
// zoom2x_frame_writer: writes the four replicated copies of each source pixel into the 2x frame buffer
module zoom2x_frame_writer
    import zoom_pkg::*;
#(
    parameter int SRC_W  = 160,
    parameter int SRC_H  = 120,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_pixel,
    input  logic [1:0]        in_idx,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              src_next,
    output logic              busy,
    output logic              frame_done,
    output logic              err_seq
);
    if (!addr_w_ok(ADDR_W, SRC_W, SRC_H)) begin : g_addr_w_check
        $error("ADDR_W too small for a 2x frame of SRC_W x SRC_H");
    end
    state_t            state, state_nx;
    logic [1:0]        exp_idx;
    logic              accept, mismatch, last, group_end, fin_acc;
    logic [ADDR_W-1:0] addr;
    zoom2x_addr_gen #(.SRC_W(SRC_W), .SRC_H(SRC_H), .ADDR_W(ADDR_W)) u_addr_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (frame_start),
        .advance (group_end && !last),
        .idx     (in_idx),
        .addr    (addr),
        .last    (last)
    );
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end
    always_comb begin
        state_nx = frame_start                 ? ACTIVE :
                   state == ACTIVE && fin_acc  ? DONE   :
                   state == DONE               ? IDLE   : state;
    end
    // frame_start swallows any in_valid of the same cycle, so it neither writes nor flags
    always_comb begin
        accept    = state == ACTIVE && in_valid && !frame_start && in_idx == exp_idx;
        mismatch  = in_valid && !frame_start && !accept;
        group_end = accept && in_idx == BR;
        fin_acc   = group_end && last;
        busy      = state == ACTIVE;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            exp_idx    <= TL;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            src_next   <= 1'b0;
            frame_done <= 1'b0;
            err_seq    <= 1'b0;
        end else begin
            exp_idx    <= frame_start ? TL : accept ? exp_idx + 1'b1 : exp_idx;
            wr_en      <= accept;
            wr_addr    <= accept ? addr : wr_addr;
            wr_data    <= accept ? in_pixel : wr_data;
            src_next   <= group_end && !last;
            frame_done <= fin_acc;
            err_seq    <= frame_start ? 1'b0 : err_seq | mismatch;
        end
    end
endmodule

// File: tb/tb_zoom2x_frame_writer.sv
// tb_zoom2x_frame_writer: directed checks of a 4x2 source frame zoomed into an 8x4 buffer
module tb_zoom2x_frame_writer;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_pixel = '0;
    logic [1:0] in_idx = '0;
    logic       wr_en, src_next, busy, frame_done, err_seq;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    int         errors = 0;
    int         checks = 0;
    int         hits [32];

    zoom2x_frame_writer #(.SRC_W(4), .SRC_H(2), .DATA_W(8), .ADDR_W(5)) dut (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .in_valid(in_valid),
        .in_pixel(in_pixel), .in_idx(in_idx), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .src_next(src_next), .busy(busy), .frame_done(frame_done),
        .err_seq(err_seq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic fs, input logic v, input logic [1:0] idx, input logic [7:0] px);
        frame_start = fs;
        in_valid    = v;
        in_idx      = idx;
        in_pixel    = px;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        in_valid    = 1'b0;
    endtask

    task automatic copy(input logic [1:0] idx, input logic [7:0] px, input int a, input bit sn, input bit fd);
        step(1'b0, 1'b1, idx, px);
        chk("wr_en", wr_en, 1);
        chk("wr_addr", wr_addr, a);
        chk("wr_data", wr_data, px);
        chk("src_next", src_next, sn);
        chk("frame_done", frame_done, fd);
        if (wr_en) hits[wr_addr]++;
    endtask

    task automatic group(input logic [7:0] px, input int a0, input bit last);
        copy(2'd0, px, a0, 1'b0, 1'b0);
        copy(2'd1, px, a0 + 1, 1'b0, 1'b0);
        copy(2'd2, px, a0 + 8, 1'b0, 1'b0);
        copy(2'd3, px, a0 + 9, !last, last);
    endtask

    initial begin
        foreach (hits[i]) hits[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_src_next", src_next, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err_seq", err_seq, 0);
        reset_n = 1'b1;
        step(1'b0, 1'b1, 2'd0, 8'h11);
        chk("idle_valid_no_write", wr_en, 0);
        chk("idle_valid_err", err_seq, 1);
        step(1'b1, 1'b0, 2'd0, 8'h00);
        chk("start_busy", busy, 1);
        chk("start_err_clear", err_seq, 0);
        // full frame: source pixel p sits at sx=p%4, sy=p/4
        for (int p = 0; p < 8; p++) begin
            group(8'hA5 + 8'(p), (p / 4) * 16 + (p % 4) * 2, p == 7);
            if (p == 7) chk("last_busy_low", busy, 0);
        end
        step(1'b0, 1'b0, 2'd0, 8'h00);
        chk("post_src_next", src_next, 0);
        chk("post_frame_done", frame_done, 0);
        chk("post_wr_en", wr_en, 0);
        chk("post_busy", busy, 0);
        chk("frame_err", err_seq, 0);
        for (int a = 0; a < 32; a++) chk($sformatf("cover_%0d", a), hits[a], 1);
        step(1'b1, 1'b0, 2'd0, 8'h00);
        copy(2'd0, 8'h3C, 0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'd2, 8'h3C);
        chk("skip_no_write", wr_en, 0);
        chk("skip_err", err_seq, 1);
        copy(2'd1, 8'h3C, 1, 1'b0, 1'b0);
        copy(2'd2, 8'h3C, 8, 1'b0, 1'b0);
        copy(2'd3, 8'h3C, 9, 1'b1, 1'b0);
        group(8'h5A, 2, 1'b0);
        copy(2'd0, 8'h77, 4, 1'b0, 1'b0);
        copy(2'd1, 8'h77, 5, 1'b0, 1'b0);
        step(1'b1, 1'b1, 2'd2, 8'h77);
        chk("restart_no_write", wr_en, 0);
        chk("restart_err_clear", err_seq, 0);
        chk("restart_busy", busy, 1);
        copy(2'd0, 8'h99, 0, 1'b0, 1'b0);
        copy(2'd1, 8'h99, 1, 1'b0, 1'b0);
        reset_n = 1'b0;
        step(1'b0, 1'b1, 2'd2, 8'h99);
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_wr_addr", wr_addr, 0);
        chk("midrst_wr_data", wr_data, 0);
        chk("midrst_busy", busy, 0);
        reset_n = 1'b1;
        step(1'b0, 1'b0, 2'd0, 8'h00);
        chk("after_rst_busy", busy, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
